data_mem_unit: RTL and testbench
================================

Name: data_mem_unit

Overview:
- Parametrised successor to the single-cycle data memory, for the multi-cycle and pipelined datapath.
- Byte-addressed, little-endian word array with byte, half-word and word load/store, and sign or zero extension on loads.
- Configurable read latency behind a valid/busy handshake; alignment and range faults reported per request.
- Keeps the integrated write-back mux that selects loaded data or the ALU result for the register file.

Parameters:
- DATA_W, 32, word width in bits; must be 32.
- DEPTH, 32, number of words (power of two, ≥ 4).
- RD_LAT, 1, cycles from read acceptance to response (1..4).
- INIT_MODE, 1, 1 = word i initialised to i at elaboration; 0 = all zero.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word; 11 is illegal and treated as a fault.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- addr  in  32  byte address (the ALU result).
- wdata  in  32  store data, taken from the low bits.
- mem_to_reg  in  1  write-back select.
- busy  out  1  read outstanding; new requests ignored.
- resp_valid  out  1  one-cycle completion pulse.
- rdata  out  32  extended load data, held between responses.
- fault  out  1  qualifies resp_valid: misaligned, out of range or illegal size.
- wb_data  out  32  mem_to_reg ? rdata : addr (combinational).

Behaviour:
- Reset (async):
  - State → IDLE; latency counter = 0.
  - busy, resp_valid, fault = 0; rdata = 0.
  - Memory array is not cleared; it keeps its INIT_MODE or written contents.
- Acceptance:
  - A request is accepted on a clock edge with req_valid=1 and state IDLE, or state RESP (back-to-back allowed).
  - Requests arriving while state is WAIT are dropped silently; the bench must respect busy.
- Word index = addr[log2(DEPTH)+1:2]; byte lane = addr[1:0].
- Faults:
  - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
  - Out of range: addr ≥ 4*DEPTH.
  - Illegal size: req_size = 11.
  - A faulting request does not modify memory and does not update rdata.
  - It responds the cycle after acceptance with resp_valid=1 and fault=1, regardless of RD_LAT.
- Store:
  - Memory is written on the accepting edge, selected lanes only; other bytes are unchanged.
  - Byte writes wdata[7:0] to lane addr[1:0]. Half writes wdata[15:0] to lanes addr[1]*2 and addr[1]*2+1. Word writes all four lanes.
  - resp_valid=1 next cycle; busy never asserts for stores.
- Load:
  - Address, size and sign flag are registered at acceptance.
  - RD_LAT=1: array read at acceptance; rdata and resp_valid update at the next edge.
  - RD_LAT>1: state WAIT with busy=1 for RD_LAT-1 cycles, then RESP.
  - Data is sampled from the array at the final edge, so a store accepted earlier is visible (no stale data).
  - Extension: byte/half sign- or zero-extended to 32 bits by req_unsigned; word passes unchanged.
- States:
  - IDLE → RESP on a store, a fault, or a load with RD_LAT=1.
  - IDLE → WAIT on a load with RD_LAT>1.
  - WAIT → RESP when the counter reaches RD_LAT-1.
  - RESP → IDLE, or stays in RESP/moves to WAIT if a new request is accepted in the same cycle.
- resp_valid is high only in RESP, for exactly one cycle per accepted request.
- busy = (state == WAIT).
- Reset asserted mid-load aborts the load with no response; memory is untouched.
- wb_data is purely combinational from mem_to_reg, rdata and addr; there is no enable gating.

Decomposition:
- Shared package (mem_pkg): size encodings SZ_BYTE/SZ_HALF/SZ_WORD, state enum IDLE/WAIT/RESP, and a function that maps size and address to byte-enable and fault.
- One sub-module, load_extend: a combinational lane select plus sign/zero extension, reusable by a later cache.

Test Plan:
- INIT_MODE=1, RD_LAT=1; load word at addr 0x14 → one cycle later resp_valid=1, rdata=0x00000005, fault=0.
- Store byte 0xAB at 0x09, then signed load byte at 0x09 → rdata=0xFFFFFFAB. Unsigned load of the same byte → 0x000000AB. Load word at 0x08 → 0x0000AB02.
- Store half 0x1234 at 0x03 → fault=1 and memory word 0 unchanged. Load word at 0x80 with DEPTH=32 → fault=1.
- RD_LAT=3: load word at 0x1C → busy high for 2 cycles, resp_valid on the 3rd edge, rdata=0x07. A req_valid pulse during busy produces no extra response.
- Store word 0xDEADBEEF at 0x10, then load word at 0x10 on the next cycle → rdata=0xDEADBEEF. With mem_to_reg=1, wb_data=0xDEADBEEF; with mem_to_reg=0, wb_data=0x10.
- RD_LAT=4: assert rst during WAIT → busy, resp_valid and rdata go 0 immediately; no response follows; memory contents are retained.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings and request decode for the data memory unit.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [3:0] be;
    logic       fault;
  } dec_t;

  // Byte enables for a request; a faulting request gets no enables so it
  // can never touch the array.
  function automatic dec_t decode_req(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input logic [31:0] lim);
    dec_t d;
    d.be    = 4'b0000;
    d.fault = 1'b0;
    case (size)
      SZ_BYTE: d.be = 4'b0001 << addr[1:0];
      SZ_HALF: begin
        d.be    = addr[1] ? 4'b1100 : 4'b0011;
        d.fault = addr[0];
      end
      SZ_WORD: begin
        d.be    = 4'b1111;
        d.fault = |addr[1:0];
      end
      default: d.fault = 1'b1;
    endcase
    if (addr >= lim) d.fault = 1'b1;
    if (d.fault) d.be = 4'b0000;
    return d;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Lane select plus sign/zero extension of a little-endian word.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] data_o
);

  logic [31:0] sh;
  assign sh = word_i >> {lane_i, 3'b000};

  // Narrow loads take the selected lane from the bottom of the shifted word.
  always_comb begin
    data_o = word_i;
    case (size_i)
      SZ_BYTE: data_o = {{24{~uns_i & sh[7]}},  sh[7:0]};
      SZ_HALF: data_o = {{16{~uns_i & sh[15]}}, sh[15:0]};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressed data memory with configurable read latency, fault
// reporting and the register-file write-back mux.
module data_mem_unit
  import mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 32,
  parameter int RD_LAT    = 1,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mem_to_reg,
  output logic              busy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              fault,
  output logic [DATA_W-1:0] wb_data
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] LIM  = 32'(4 * DEPTH);
  localparam logic [2:0]  LAST = 3'(RD_LAT - 1);

  typedef logic [3:0][7:0] word_t;
  typedef word_t mem_t [DEPTH];

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) m[i] = (INIT_MODE != 0) ? word_t'(i) : '0;
    return m;
  endfunction

  // Contents survive reset; only the elaboration-time image seeds them.
  mem_t mem_q = mem_init();

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic [31:0] rdata_q, rdata_d;
  logic [AW-1:0] idx_q;
  logic [1:0]  lane_q, size_q;
  logic        uns_q;

  logic        accept;
  dec_t        dec;
  logic [AW-1:0] idx_req;
  word_t       wlanes;
  logic        in_wait;
  logic [31:0] rd_word, ext_data;
  logic [1:0]  rd_lane, rd_size;
  logic        rd_uns;

  assign in_wait = (state_q == WAIT);
  assign accept  = req_valid & ~rst & ~in_wait;
  assign dec     = decode_req(req_size, addr, LIM);
  assign idx_req = addr[AW+1:2];

  // Replicate store data so each enabled lane sees its own bytes.
  assign wlanes = (req_size == SZ_BYTE) ? {4{wdata[7:0]}}  :
                  (req_size == SZ_HALF) ? {2{wdata[15:0]}} : wdata;

  // A load finishing out of WAIT reads with its registered request; a
  // single-cycle load reads straight from the live request.
  assign rd_word = in_wait ? mem_q[idx_q] : mem_q[idx_req];
  assign rd_lane = in_wait ? lane_q : addr[1:0];
  assign rd_size = in_wait ? size_q : req_size;
  assign rd_uns  = in_wait ? uns_q  : req_unsigned;

  load_extend u_ext (
    .word_i (rd_word),
    .lane_i (rd_lane),
    .size_i (rd_size),
    .uns_i  (rd_uns),
    .data_o (ext_data)
  );

  // Store path: enabled lanes only, written on the accepting edge.
  always_ff @(posedge clk) begin
    if (accept && req_write) begin
      for (int b = 0; b < 4; b++)
        if (dec.be[b]) mem_q[idx_req][b] <= wlanes[b];
    end
  end

  // Next-state: IDLE/RESP accept new work, WAIT counts down the latency.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fault_d = fault_q;
    rdata_d = rdata_q;
    case (state_q)
      WAIT: begin
        if (cnt_q == LAST) begin
          state_d = RESP;
          fault_d = 1'b0;
          rdata_d = ext_data;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        if (accept) begin
          fault_d = dec.fault;
          if (!req_write && !dec.fault && RD_LAT > 1) begin
            state_d = WAIT;
            cnt_d   = 3'd1;
          end else begin
            state_d = RESP;
            if (!req_write && !dec.fault) rdata_d = ext_data;
          end
        end
      end
    endcase
  end

  // Control and captured request; reset aborts any load in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
      idx_q   <= '0;
      lane_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
      rdata_q <= rdata_d;
      if (accept) begin
        idx_q  <= idx_req;
        lane_q <= addr[1:0];
        size_q <= req_size;
        uns_q  <= req_unsigned;
      end
    end
  end

  assign busy       = in_wait;
  assign resp_valid = (state_q == RESP);
  assign fault      = resp_valid & fault_q;
  assign rdata      = rdata_q;
  assign wb_data    = mem_to_reg ? rdata_q : addr;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench: three instances (RD_LAT 1/3/4) against a byte-array reference.
module tb_data_mem_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        rv  [3];
  logic        wr, uns, m2r;
  logic [1:0]  sz;
  logic [31:0] a, wd;
  logic        busy_w [3];
  logic        resp_w [3];
  logic        fault_w[3];
  logic [31:0] rdata_w[3];
  logic [31:0] wb_w   [3];

  int          LAT [3] = '{1, 3, 4};
  byte unsigned ref_mem [3][128];
  logic [31:0] ref_rd [3];
  int unsigned checks = 0;
  int unsigned errors = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_unit #(.DATA_W(32), .DEPTH(32), .RD_LAT((g == 0) ? 1 : g + 2), .INIT_MODE(1)) u_dut (
      .clk(clk), .rst(rst[g]), .req_valid(rv[g]), .req_write(wr), .req_size(sz),
      .req_unsigned(uns), .addr(a), .wdata(wd), .mem_to_reg(m2r),
      .busy(busy_w[g]), .resp_valid(resp_w[g]), .rdata(rdata_w[g]),
      .fault(fault_w[g]), .wb_data(wb_w[g]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic bit m_fault(input logic [1:0] s, input logic [31:0] ad);
    return (s == 2'b11) || (s == 2'b01 && ad[0]) || (s == 2'b10 && ad[1:0] != 2'b00) ||
           (ad >= 32'd128);
  endfunction

  function automatic logic [31:0] m_load(input int d, input logic [1:0] s, input bit u,
                                         input logic [31:0] ad);
    int n;
    logic [31:0] v;
    n = 1 << s;
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[d][ad + i]) << (8 * i));
    if (n < 4 && !u && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic m_store(input int d, input logic [1:0] s, input logic [31:0] ad,
                         input logic [31:0] wdv);
    for (int i = 0; i < (1 << s); i++) ref_mem[d][ad + i] = wdv[8 * i +: 8];
  endtask

  // One request on DUT d, checked through busy cycles to its response.
  task automatic req(input int d, input bit w, input logic [1:0] s, input bit u,
                     input logic [31:0] ad, input logic [31:0] wdv);
    bit f;
    f = m_fault(s, ad);
    @(negedge clk);
    wr = w; sz = s; uns = u; a = ad; wd = wdv; m2r = 1'($urandom); rv[d] = 1'b1;
    @(negedge clk);
    rv[d] = 1'b0;
    if (!f && w) m_store(d, s, ad, wdv);
    if (!f && !w) begin
      for (int c = 1; c < LAT[d]; c++) begin
        chk("busy_during_wait", busy_w[d], 1);
        chk("no_resp_in_wait", resp_w[d], 0);
        @(negedge clk);
      end
      ref_rd[d] = m_load(d, s, u, ad);
    end
    chk("resp_valid", resp_w[d], 1);
    chk("fault", fault_w[d], f);
    chk("busy_at_resp", busy_w[d], 0);
    chk("rdata", rdata_w[d], ref_rd[d]);
    chk("wb_data", wb_w[d], m2r ? ref_rd[d] : ad);
    @(negedge clk);
    chk("resp_one_cycle", resp_w[d], 0);
  endtask

  initial begin
    logic [31:0] ad;
    logic [1:0]  s;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; rv[d] = 1'b0; ref_rd[d] = '0;
      for (int k = 0; k < 128; k++) ref_mem[d][k] = (k % 4 == 0) ? 8'(k / 4) : 8'd0;
    end
    wr = 0; uns = 0; m2r = 0; sz = 0; a = 0; wd = 0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk("reset_busy", busy_w[d], 0);
      chk("reset_resp", resp_w[d], 0);
      chk("reset_fault", fault_w[d], 0);
      chk("reset_rdata", rdata_w[d], 0);
    end
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;

    // Single-cycle latency directed cases.
    req(0, 0, 2'b10, 0, 32'h14, 0);
    chk("ld_word_14", rdata_w[0], 32'h5);
    req(0, 1, 2'b00, 0, 32'h09, 32'h123456AB);
    req(0, 0, 2'b00, 0, 32'h09, 0);
    chk("ld_sbyte_09", rdata_w[0], 32'hFFFFFFAB);
    req(0, 0, 2'b00, 1, 32'h09, 0);
    chk("ld_ubyte_09", rdata_w[0], 32'h000000AB);
    req(0, 0, 2'b10, 0, 32'h08, 0);
    chk("ld_word_08", rdata_w[0], 32'h0000AB02);
    req(0, 1, 2'b01, 0, 32'h03, 32'h1234);
    req(0, 0, 2'b10, 0, 32'h00, 0);
    chk("word0_untouched", rdata_w[0], 32'h0);
    req(0, 0, 2'b10, 0, 32'h80, 0);
    req(0, 0, 2'b11, 0, 32'h04, 0);

    // Back-to-back store then load from RESP.
    @(negedge clk);
    wr = 1; sz = 2'b10; uns = 0; a = 32'h10; wd = 32'hDEADBEEF; m2r = 1; rv[0] = 1'b1;
    @(negedge clk);
    chk("b2b_store_resp", resp_w[0], 1);
    m_store(0, 2'b10, 32'h10, 32'hDEADBEEF);
    wr = 0;
    @(negedge clk);
    rv[0] = 1'b0;
    ref_rd[0] = m_load(0, 2'b10, 0, 32'h10);
    chk("b2b_load_resp", resp_w[0], 1);
    chk("b2b_load_data", rdata_w[0], 32'hDEADBEEF);
    chk("wb_mem", wb_w[0], 32'hDEADBEEF);
    m2r = 0; #1;
    chk("wb_alu", wb_w[0], 32'h10);

    // RD_LAT=3 with a request pulse during busy that must be dropped.
    @(negedge clk);
    wr = 0; sz = 2'b10; uns = 0; a = 32'h1C; m2r = 0; rv[1] = 1'b1;
    @(negedge clk);
    rv[1] = 1'b0;
    chk("lat3_busy1", busy_w[1], 1);
    wr = 1; wd = 32'hFFFFFFFF; rv[1] = 1'b1;
    @(negedge clk);
    rv[1] = 1'b0;
    chk("lat3_busy2", busy_w[1], 1);
    chk("lat3_no_resp", resp_w[1], 0);
    @(negedge clk);
    chk("lat3_resp", resp_w[1], 1);
    chk("lat3_busy_low", busy_w[1], 0);
    chk("lat3_rdata", rdata_w[1], 32'h7);
    ref_rd[1] = 32'h7;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("lat3_no_extra_resp", resp_w[1], 0);
    end
    req(1, 0, 2'b10, 0, 32'h1C, 0);
    chk("lat3_store_dropped", rdata_w[1], 32'h7);

    // RD_LAT=4: reset in WAIT aborts the load, memory retained.
    req(2, 0, 2'b10, 0, 32'h1C, 0);
    @(negedge clk);
    wr = 0; sz = 2'b10; a = 32'h04; rv[2] = 1'b1;
    @(negedge clk);
    rv[2] = 1'b0;
    chk("lat4_busy", busy_w[2], 1);
    rst[2] = 1'b1; #1;
    chk("rst_busy", busy_w[2], 0);
    chk("rst_resp", resp_w[2], 0);
    chk("rst_rdata", rdata_w[2], 0);
    ref_rd[2] = '0;
    @(negedge clk);
    rst[2] = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("rst_no_resp", resp_w[2], 0);
      chk("rst_no_busy", busy_w[2], 0);
    end
    req(2, 0, 2'b10, 0, 32'h1C, 0);
    chk("rst_mem_kept", rdata_w[2], 32'h7);

    // Randomized traffic on every instance.
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 60; n++) begin
        s  = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        ad = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(128, 300)) :
                                           32'($urandom_range(0, 127));
        if ($urandom_range(0, 3) != 0) begin
          if (s == 2'b01) ad[0] = 1'b0;
          if (s == 2'b10) ad[1:0] = 2'b00;
        end
        req(d, 1'($urandom), s, 1'($urandom), ad, $urandom);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
